pwrite_shift: RTL and testbench
===============================

PWRITE_SHIFT -- requirements
Module: pwrite_shift

Interface
REQ-001 SHALL have parameter WRITE_WIDTH, default 32: width of the parallel word loaded for transmission.
REQ-002 SHALL have parameter OUT_WIDTH, default 8: width of each serialized output chunk ("byte").
REQ-003 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port din, input, WRITE_WIDTH: parallel word, sampled only on an accepted load.
REQ-006 SHALL have port enable, input, 1: load request.
REQ-007 SHALL have port busy, output, 1: word held and not yet fully transmitted.
REQ-008 SHALL have port dout, output, OUT_WIDTH: current outgoing byte.
REQ-009 SHALL have port dout_valid, output, 1: dout holds a byte offered to the consumer.
REQ-010 SHALL have port dout_ready, input, 1: consumer accepts dout this cycle.
REQ-011 SHALL have port dout_last, output, 1: current byte is the final byte of the word.
REQ-012 SHALL have port done, output, 1: one-cycle pulse after the final byte is accepted.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE; all outputs driven from registers.
REQ-014 SHALL define BYTES = WRITE_WIDTH/OUT_WIDTH and a byte counter of width $clog2(BYTES).
REQ-015 SHALL accept a load when the state is IDLE or DONE and enable=1: latch din into the shift register, set counter=BYTES-1, enter SHIFT.
REQ-016 SHALL ignore enable while in SHIFT; din changes during SHIFT have no effect.
REQ-017 SHALL present the most-significant byte first: dout = shift_reg[WRITE_WIDTH-1 -: OUT_WIDTH] in SHIFT. This order matches the byte order assembled by the team's parallel-read shifter.
REQ-018 SHALL hold dout_valid=1 and dout, dout_last stable in SHIFT until dout_valid && dout_ready, which is a transfer.
REQ-019 On a transfer with counter!=0, SHALL shift the register left by OUT_WIDTH, zero-fill, and decrement the counter.
REQ-020 On a transfer with counter==0, SHALL enter DONE.
REQ-021 SHALL assert dout_last in SHIFT exactly when counter==0.
REQ-022 SHALL assert done=1, busy=0 and dout_valid=0 for exactly the DONE cycle; DONE then goes to IDLE, or to SHIFT if a load is accepted per REQ-015.
REQ-023 SHALL drive dout=0, dout_valid=0, dout_last=0 outside SHIFT; busy=1 exactly in SHIFT.
REQ-024 Latency: load accepted at edge N gives dout_valid=1 from edge N; with dout_ready held high, bytes transfer at edges N+1..N+BYTES and done is high after edge N+BYTES.
REQ-025 SHALL treat dout_ready while dout_valid=0 as no-op.
REQ-026 SHALL require WRITE_WIDTH to be an integer multiple of OUT_WIDTH with BYTES>=2; otherwise the design SHALL raise an elaboration error.

Reset
REQ-027 SHALL, on reset assertion at any time including mid-word, force state IDLE, shift register 0, counter 0, busy=0, dout=0, dout_valid=0, dout_last=0, done=0 (and dout_par=0 when present).
REQ-028 SHALL NOT emit done for a word aborted by reset.
REQ-029 SHALL accept a load on the first rising clk edge after reset deasserts.

Configuration
REQ-030 With PWRITE_SHIFT_PARITY_EN defined, SHALL add output dout_par (1 bit) = XOR of dout bits, valid alongside dout_valid and 0 outside SHIFT.
REQ-031 Without PWRITE_SHIFT_PARITY_EN, SHALL omit port dout_par; all other behaviour is identical.

Structure
REQ-032 SHALL take the state enumeration (IDLE/SHIFT/DONE) and default width constants (32, 8) from shared package pshift_pkg, which is also usable by the read shifter.
REQ-033 SHALL instantiate sub-module pshift_par_gen (parameter OUT_WIDTH, combinational XOR reduce) only when PWRITE_SHIFT_PARITY_EN is defined; no other sub-modules.

Verification
REQ-034 Load din=32'hDEADBEEF, dout_ready=1 -> dout DE,AD,BE,EF on 4 consecutive cycles; dout_last only on EF; done pulses 1 cycle; busy high 4 cycles.
REQ-035 Load 32'h01020304, dout_ready toggles 1,0,0,1,1,0,1 -> bytes 01..04 each held stable while stalled; exactly 4 transfers; single done.
REQ-036 enable held high continuously with din=32'hA5A5_0F0F then 32'h1234_5678 at first DONE -> second word loaded in DONE cycle; output A5,A5,0F,0F,12,34,56,78; two done pulses.
REQ-037 Reset asserted after second byte of 32'hCAFEF00D -> all outputs 0 immediately, no done; new load of 32'h00000001 emits 00,00,00,01.
REQ-038 With PWRITE_SHIFT_PARITY_EN, word 32'h0103_07FF -> dout_par sequence 1,0,1,0.

Source files
------------

// File: rtl/pshift_pkg.sv
// pshift_pkg: shared definitions for the parallel-write and parallel-read shifters.
//   - pshift_state_e     : IDLE / SHIFT / DONE state encoding
//   - PSHIFT_WRITE_WIDTH : default parallel word width (32)
//   - PSHIFT_OUT_WIDTH   : default serial chunk width (8)
package pshift_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } pshift_state_e;

    localparam int unsigned PSHIFT_WRITE_WIDTH = 32;
    localparam int unsigned PSHIFT_OUT_WIDTH   = 8;

endpackage

// File: rtl/pshift_par_gen.sv
// pshift_par_gen: combinational even-parity (XOR reduce) of one output chunk.
// Ports:
//   data [OUT_WIDTH-1:0] in  : chunk to cover
//   par                  out : XOR of all bits of data
module pshift_par_gen #(
    parameter int unsigned OUT_WIDTH = 8
) (
    input  logic [OUT_WIDTH-1:0] data,
    output logic                 par
);

    assign par = ^data;

endmodule

// File: rtl/pwrite_shift.sv
// pwrite_shift: loads a WRITE_WIDTH word and streams it out MSB chunk first as
// OUT_WIDTH-bit bytes over a valid/ready handshake, then pulses done for one cycle.
// Optional feature: define PWRITE_SHIFT_PARITY_EN to add the dout_par output.
// Ports:
//   clk        in  : clock, rising edge
//   reset      in  : asynchronous active-high reset
//   din        in  : parallel word, sampled only when a load is accepted
//   enable     in  : load request (honoured in IDLE or DONE)
//   busy       out : word held and not yet fully transmitted
//   dout       out : current outgoing byte
//   dout_valid out : dout is offered to the consumer
//   dout_ready in  : consumer accepts dout this cycle
//   dout_last  out : current byte is the final byte of the word
//   done       out : one-cycle pulse after the final byte is accepted
//   dout_par   out : XOR of dout bits (only with PWRITE_SHIFT_PARITY_EN)
module pwrite_shift
    import pshift_pkg::*;
#(
    parameter int unsigned WRITE_WIDTH = PSHIFT_WRITE_WIDTH,
    parameter int unsigned OUT_WIDTH   = PSHIFT_OUT_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WRITE_WIDTH-1:0] din,
    input  logic                   enable,
    output logic                   busy,
    output logic [OUT_WIDTH-1:0]   dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic                   dout_last,
    output logic                   done
`ifdef PWRITE_SHIFT_PARITY_EN
    ,
    output logic                   dout_par
`endif
);

    localparam int unsigned BYTES = WRITE_WIDTH / OUT_WIDTH;
    localparam int unsigned CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    if ((WRITE_WIDTH % OUT_WIDTH) != 0 || BYTES < 2) begin : g_bad_params
        $error("pwrite_shift: WRITE_WIDTH must be a multiple of OUT_WIDTH with at least 2 bytes");
    end

    pshift_state_e          state_q, state_d;
    logic [WRITE_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic [OUT_WIDTH-1:0]   dout_q, dout_d;
    logic                   valid_q, valid_d;
    logic                   last_q, last_d;
    logic                   done_q, done_d;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (enable) begin
                    shift_d = din;
                    cnt_d   = CNT_W'(BYTES - 1);
                    state_d = StShift;
                end else begin
                    state_d = StIdle;
                end
            end
            StShift: begin
                // valid is always high in SHIFT, so ready alone marks a transfer
                if (dout_ready) begin
                    if (cnt_q != '0) begin
                        shift_d = shift_q << OUT_WIDTH;
                        cnt_d   = cnt_q - 1'b1;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered from the next state so they line up with it.
        busy_d  = (state_d == StShift);
        valid_d = busy_d;
        dout_d  = busy_d ? shift_d[WRITE_WIDTH-1 -: OUT_WIDTH] : '0;
        last_d  = busy_d && (cnt_d == '0);
        done_d  = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            shift_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign busy       = busy_q;
    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign dout_last  = last_q;
    assign done       = done_q;

`ifdef PWRITE_SHIFT_PARITY_EN
    // dout_q is zero outside SHIFT, so parity is zero there too.
    pshift_par_gen #(
        .OUT_WIDTH(OUT_WIDTH)
    ) u_par_gen (
        .data(dout_q),
        .par (dout_par)
    );
`endif

endmodule

// File: tb/tb_pwrite_shift.sv
module tb_pwrite_shift;

    localparam int unsigned NB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] din;
    logic        enable;
    logic        busy;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        dout_last;
    logic        done;
`ifdef PWRITE_SHIFT_PARITY_EN
    logic        dout_par;
`endif

    pwrite_shift #(
        .WRITE_WIDTH(32),
        .OUT_WIDTH  (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .enable    (enable),
        .busy      (busy),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .dout_last (dout_last),
        .done      (done)
`ifdef PWRITE_SHIFT_PARITY_EN
        ,
        .dout_par  (dout_par)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   pending  = 0;
    logic exp_done = 1'b0;
    int   done_cnt = 0;
    int   xfer_cnt = 0;
    int   d0;
    int   x0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check outputs against the scoreboard, advance.
    task automatic cycle(input logic en, input logic [31:0] d, input logic rdy);
        exp_t e;
        logic accept;
        enable     = en;
        din        = d;
        dout_ready = rdy;
        #1;
        check("done", {31'd0, done}, {31'd0, exp_done});
        if (done === 1'b1) done_cnt++;
        check("busy", {31'd0, busy}, {31'd0, pending != 0});
        check("valid", {31'd0, dout_valid}, {31'd0, pending != 0});
        accept   = en && (pending == 0);
        exp_done = 1'b0;
        if (pending != 0) begin
            e = sb[0];
            check("dout", {24'd0, dout}, {24'd0, e.data});
            check("last", {31'd0, dout_last}, {31'd0, e.last});
`ifdef PWRITE_SHIFT_PARITY_EN
            check("par", {31'd0, dout_par}, {31'd0, ^e.data});
`endif
            if (rdy) begin
                void'(sb.pop_front());
                xfer_cnt++;
                pending--;
                if (pending == 0) exp_done = 1'b1;
            end
        end else begin
            check("dout_idle", {24'd0, dout}, 32'd0);
            check("last_idle", {31'd0, dout_last}, 32'd0);
`ifdef PWRITE_SHIFT_PARITY_EN
            check("par_idle", {31'd0, dout_par}, 32'd0);
`endif
        end
        if (accept) begin
            for (int i = 0; i < NB; i++) begin
                sb.push_back('{data: d[31-8*i -: 8], last: (i == NB - 1)});
            end
            pending = NB;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_dout"}, {24'd0, dout}, 32'd0);
        check({tag, "_valid"}, {31'd0, dout_valid}, 32'd0);
        check({tag, "_last"}, {31'd0, dout_last}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    logic rdy_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        din        = '0;
        dout_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Back-to-back stream with ready high; load on first edge after reset.
        d0 = done_cnt; x0 = xfer_cnt;
        cycle(1'b1, 32'hDEAD_BEEF, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1);
        check("t1_done_cnt", done_cnt - d0, 1);
        check("t1_xfers", xfer_cnt - x0, 4);
        check("t1_sb_empty", sb.size(), 0);

        // Stalls: ready low before valid is a no-op, then toggling pattern.
        d0 = done_cnt; x0 = xfer_cnt;
        cycle(1'b1, 32'h0102_0304, 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b0, 32'hFFFF_FFFF, rdy_pat[i]);
        for (int i = 0; i < 2; i++) cycle(1'b0, 32'h0, 1'b0);
        check("t2_done_cnt", done_cnt - d0, 1);
        check("t2_xfers", xfer_cnt - x0, 4);
        check("t2_sb_empty", sb.size(), 0);

        // enable held high: din changes ignored in SHIFT, reload in DONE cycle.
        d0 = done_cnt; x0 = xfer_cnt;
        cycle(1'b1, 32'hA5A5_0F0F, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h1234_5678, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1);
        check("t3_done_cnt", done_cnt - d0, 2);
        check("t3_xfers", xfer_cnt - x0, 8);
        check("t3_sb_empty", sb.size(), 0);

        // Reset mid-word: outputs clear at once, no done for aborted word.
        d0 = done_cnt;
        cycle(1'b1, 32'hCAFE_F00D, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        reset = 1'b1;
        #1;
        check_all_zero("abort");
        sb.delete();
        pending  = 0;
        exp_done = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("abort_hold");
        reset = 1'b0;
        check("t4_no_done", done_cnt - d0, 0);
        d0 = done_cnt; x0 = xfer_cnt;
        cycle(1'b1, 32'h0000_0001, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1);
        check("t4_done_cnt", done_cnt - d0, 1);
        check("t4_xfers", xfer_cnt - x0, 4);

`ifdef PWRITE_SHIFT_PARITY_EN
        // Parity sequence 1,0,1,0 is checked per byte inside cycle().
        cycle(1'b1, 32'h0103_07FF, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1);
`endif

        check("final_sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
